distinct_ctrl: RTL and testbench
================================

Name: distinct_ctrl

Overview:
- Sequencer that drives the distinct hash table (lookup, update and clear ports) to turn an input key stream into a stream of first occurrences.
- Issues one lookup per input key and consumes the responses in order.
- On a miss it emits the key downstream and writes it into the table. Exact hits are dropped.
- At each end of stream it drains in-flight lookups and then clears the table before accepting the next stream.

Parameters:
KEY_BITS, 32, key width; must equal table key width
MAX_OUT, 4, maximum lookups in flight (issued but response not yet consumed); power of 2, ≥2
RECENT_DEPTH, 8, depth of the recently-inserted key window; ≥ table update-to-visible latency + lookup latency (5)
CNT_BITS, 32, statistics counter width

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_key_valid/s_key_ready  in/out  1  input stream handshake
s_key_data  in  KEY_BITS  input key
s_key_last  in  1  last key of stream
m_lup_valid/m_lup_ready  out/in  1  lookup request handshake to table
m_lup_key  out  KEY_BITS  lookup key
m_lup_last  out  1  last flag forwarded through table
s_rsp_valid/s_rsp_ready  in/out  1  lookup response handshake from table
s_rsp_key  in  KEY_BITS  stored key at hashed slot (unused by control)
s_rsp_hit  in  1  table hit
s_rsp_last  in  1  returned last flag
m_upd_valid  out  1  table update strobe; table update port is always ready
m_upd_key  out  KEY_BITS  key to insert
tbl_clear  out  1  table clear pulse
m_out_valid/m_out_ready  out/in  1  output stream handshake
m_out_key  out  KEY_BITS  distinct key
m_out_keep  out  1  1 = beat carries a key; 0 = last-only marker
m_out_last  out  1  end of stream
stat_in/stat_out  out  CNT_BITS  per-stream keys in / keys emitted, latched at stream end
busy  out  1  state != RUN

Behaviour:
- Reset is synchronous on aresetn=0. All valids, tbl_clear, stat_*, the outstanding counter and the recent window valid bits go to 0. State goes to RUN.
- Reset mid-stream discards all in-flight state. A bench must not expect further responses after reset.
- FSM states are RUN, DRAIN and CLEAR.
  - RUN: s_key_ready = m_lup_ready && outst < MAX_OUT. The lookup channel is a combinational pass-through: m_lup_valid = s_key_valid && outst < MAX_OUT. An accepted key with last=1 moves the FSM to DRAIN and drops s_key_ready.
  - DRAIN: no new lookups. When outst==0 and the output register is empty or being consumed, go to CLEAR.
  - CLEAR: tbl_clear=1 for exactly one cycle. Recent window valid bits clear and the per-stream counters reset to 0. Next state is RUN. busy=1 in DRAIN and CLEAR.
- Outstanding counter outst:
  - +1 on lookup handshake, −1 on response handshake.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds MAX_OUT and never underflows.
- Responses: s_rsp_ready = !m_out_valid || m_out_ready, using a single output register. dup = s_rsp_hit || key matches any valid recent window entry.
  - Miss and not dup: in the consume cycle assert m_upd_valid=1 for one cycle with m_upd_key=s_rsp_key_req. Push the key into the recent window as a FIFO that overwrites the oldest entry on wrap. Register an output beat with keep=1 and last=s_rsp_last.
  - dup and last=1: register a beat with keep=0, last=1.
  - dup and last=0: no output beat.
- The requested key is not returned by the table. The controller therefore keeps a MAX_OUT-deep FIFO of issued keys, pushed on lookup handshake and popped on response handshake; s_rsp_key_req is this FIFO head. s_rsp_key is ignored.
- Output register holds its beat until m_out_ready. Latency from response handshake to m_out_valid is 1 cycle.
- Hash collisions evict the resident key. A later repeat of the evicted key beyond the recent window is re-emitted. This is accepted behaviour and counted in stat_out.
- Statistics:
  - stat_in increments per lookup handshake.
  - stat_out increments per keep=1 beat consumed.
  - Both wrap modulo 2^CNT_BITS.
  - On the CLEAR cycle the running counts are latched to stat_in/stat_out; they hold until the next CLEAR.
- tbl_clear and m_upd_valid never assert in the same cycle, because DRAIN guarantees no consume occurs in CLEAR.

Test Plan:
- Keys 5,7,5,9,7,last on 11, table returns hit for repeats, m_out_ready=1 → output 5,7,9,11 (keep=1); last=1 on 11; stat_in=6, stat_out=4; tbl_clear one cycle after the 11 beat is consumed.
- Key 3 then 3 back-to-back, table returns miss for both (update not yet visible) → one output 3; second dropped via recent window; one m_upd_valid.
- Stream ending with a duplicate last key (4,4 last) → beats 4 (keep=1,last=0), then keep=0,last=1.
- m_lup_ready=1, table withholds responses → exactly MAX_OUT=4 lookups accepted, then s_key_ready=0 until one response is consumed.
- m_out_ready=0 for 10 cycles with 4 responses pending → s_rsp_ready=0 after the first beat; no loss, order preserved, no duplicate updates.
- Reset asserted in DRAIN with outst=2 → all outputs 0, busy=0, next stream key 5 is emitted even though it was seen before reset (window cleared).

Source files
------------

// File: rtl/distinct_ctrl.sv
// rtl/distinct_ctrl.sv - sequencer turning a key stream into first occurrences via the distinct hash table
module distinct_ctrl #(
  parameter int KEY_BITS     = 32,
  parameter int MAX_OUT      = 4,
  parameter int RECENT_DEPTH = 8,
  parameter int CNT_BITS     = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                s_key_valid,
  output logic                s_key_ready,
  input  logic [KEY_BITS-1:0] s_key_data,
  input  logic                s_key_last,
  output logic                m_lup_valid,
  input  logic                m_lup_ready,
  output logic [KEY_BITS-1:0] m_lup_key,
  output logic                m_lup_last,
  input  logic                s_rsp_valid,
  output logic                s_rsp_ready,
  input  logic [KEY_BITS-1:0] s_rsp_key,
  input  logic                s_rsp_hit,
  input  logic                s_rsp_last,
  output logic                m_upd_valid,
  output logic [KEY_BITS-1:0] m_upd_key,
  output logic                tbl_clear,
  output logic                m_out_valid,
  input  logic                m_out_ready,
  output logic [KEY_BITS-1:0] m_out_key,
  output logic                m_out_keep,
  output logic                m_out_last,
  output logic [CNT_BITS-1:0] stat_in,
  output logic [CNT_BITS-1:0] stat_out,
  output logic                busy
);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int RW    = $clog2(RECENT_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
  state_t state, state_nxt;

  logic [OUT_W-1:0]        outst;
  logic [KEY_BITS-1:0]     req_fifo [MAX_OUT];
  logic [PTR_W-1:0]        req_wr, req_rd;
  logic [KEY_BITS-1:0]     recent_key [RECENT_DEPTH];
  logic [RECENT_DEPTH-1:0] recent_vld;
  logic [RW-1:0]           recent_wr;
  logic [CNT_BITS-1:0]     run_in, run_out;
  logic                    room, lup_hs, rsp_hs, out_hs, recent_hit, dup;
  logic [KEY_BITS-1:0]     key_req;
  logic                    unused_rsp_key;

  // The table never returns the requested key, so the head of the issued-key FIFO stands in for it.
  assign unused_rsp_key = ^s_rsp_key;
  assign room        = outst < OUT_W'(MAX_OUT);
  assign lup_hs      = m_lup_valid && m_lup_ready;
  assign s_rsp_ready = !m_out_valid || m_out_ready;
  assign rsp_hs      = s_rsp_valid && s_rsp_ready;
  assign out_hs      = m_out_valid && m_out_ready;
  assign key_req     = req_fifo[req_rd];
  assign m_lup_key   = s_key_data;
  assign m_lup_last  = s_key_last;

  always_comb begin
    recent_hit = 1'b0;
    for (int i = 0; i < RECENT_DEPTH; i++)
      if (recent_vld[i] && recent_key[i] == key_req) recent_hit = 1'b1;
  end

  assign dup         = s_rsp_hit || recent_hit;
  assign m_upd_valid = rsp_hs && !dup;
  assign m_upd_key   = key_req;

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (lup_hs && s_key_last) state_nxt = DRAIN;
      DRAIN:   if (outst == '0 && (!m_out_valid || m_out_ready)) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    s_key_ready = 1'b0;
    m_lup_valid = 1'b0;
    tbl_clear   = 1'b0;
    busy        = 1'b1;
    case (state)
      RUN: begin
        s_key_ready = m_lup_ready && room;
        m_lup_valid = s_key_valid && room;
        busy        = 1'b0;
      end
      CLEAR:   tbl_clear = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (lup_hs) req_fifo[req_wr] <= s_key_data;
    if (m_upd_valid) recent_key[recent_wr] <= key_req;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      outst       <= '0;
      req_wr      <= '0;
      req_rd      <= '0;
      recent_vld  <= '0;
      recent_wr   <= '0;
      m_out_valid <= 1'b0;
      m_out_key   <= '0;
      m_out_keep  <= 1'b0;
      m_out_last  <= 1'b0;
      run_in      <= '0;
      run_out     <= '0;
      stat_in     <= '0;
      stat_out    <= '0;
    end else begin
      if (lup_hs) req_wr <= req_wr + 1'b1;
      if (rsp_hs) req_rd <= req_rd + 1'b1;
      case ({lup_hs, rsp_hs})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: ;
      endcase

      if (m_upd_valid) begin
        recent_vld[recent_wr] <= 1'b1;
        recent_wr <= (recent_wr == RW'(RECENT_DEPTH - 1)) ? '0 : recent_wr + 1'b1;
      end

      // A duplicate still has to carry the end-of-stream marker downstream.
      if (rsp_hs && (!dup || s_rsp_last)) begin
        m_out_valid <= 1'b1;
        m_out_key   <= key_req;
        m_out_keep  <= !dup;
        m_out_last  <= s_rsp_last;
      end else if (out_hs) begin
        m_out_valid <= 1'b0;
      end

      if (lup_hs) run_in <= run_in + 1'b1;
      if (out_hs && m_out_keep) run_out <= run_out + 1'b1;

      if (state == CLEAR) begin
        stat_in    <= run_in;
        stat_out   <= run_out;
        run_in     <= '0;
        run_out    <= '0;
        recent_vld <= '0;
        recent_wr  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_distinct_ctrl.sv
// tb/tb_distinct_ctrl.sv - randomized scoreboard bench for distinct_ctrl
module tb_distinct_ctrl;
  localparam int KB = 32;
  localparam int CB = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_key_valid = 1'b0, s_key_ready, s_key_last = 1'b0;
  logic [KB-1:0] s_key_data = '0;
  logic          m_lup_valid, m_lup_ready = 1'b1, m_lup_last;
  logic [KB-1:0] m_lup_key;
  logic          s_rsp_valid = 1'b0, s_rsp_ready, s_rsp_hit = 1'b0, s_rsp_last = 1'b0;
  logic [KB-1:0] s_rsp_key = '0;
  logic          m_upd_valid, tbl_clear;
  logic [KB-1:0] m_upd_key;
  logic          m_out_valid, m_out_ready = 1'b1, m_out_keep, m_out_last;
  logic [KB-1:0] m_out_key;
  logic [CB-1:0] stat_in, stat_out;
  logic          busy;

  distinct_ctrl #(.KEY_BITS(KB), .MAX_OUT(4), .RECENT_DEPTH(8), .CNT_BITS(CB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_key_valid(s_key_valid), .s_key_ready(s_key_ready), .s_key_data(s_key_data), .s_key_last(s_key_last),
    .m_lup_valid(m_lup_valid), .m_lup_ready(m_lup_ready), .m_lup_key(m_lup_key), .m_lup_last(m_lup_last),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_key(s_rsp_key), .s_rsp_hit(s_rsp_hit),
    .s_rsp_last(s_rsp_last), .m_upd_valid(m_upd_valid), .m_upd_key(m_upd_key), .tbl_clear(tbl_clear),
    .m_out_valid(m_out_valid), .m_out_ready(m_out_ready), .m_out_key(m_out_key), .m_out_keep(m_out_keep),
    .m_out_last(m_out_last), .stat_in(stat_in), .stat_out(stat_out), .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {logic [KB-1:0] key; logic last;} req_t;
  typedef struct {logic [KB-1:0] key; logic keep; logic last;} beat_t;
  typedef struct {logic [KB-1:0] key; int due;} upd_t;

  req_t  req_q[$];
  beat_t exp_q[$];
  upd_t  pend_q[$];
  bit    tbl[logic [KB-1:0]];
  bit    seen[logic [KB-1:0]];

  int checks = 0, errors = 0, cyc = 0;
  int upd_count = 0, clr_count = 0, lup_count = 0, beat_cyc = -1, clr_cyc = -1;
  int upd_dly = 2, rdy_mode = 1, lup_mode = 1, rsp_gap = 0;
  int s_len = 0, s_uniq = 0, upd_base = 0, clr_base = 0;
  bit rsp_taken = 0, rsp_hold = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Monitor: table model bookkeeping and output scoreboard.
  initial forever begin
    beat_t e;
    @(negedge aclk);
    if (!aresetn) begin
      tbl.delete();
      pend_q.delete();
    end else begin
      for (int i = pend_q.size() - 1; i >= 0; i--)
        if (pend_q[i].due <= cyc) begin
          tbl[pend_q[i].key] = 1'b1;
          pend_q.delete(i);
        end
      if (m_lup_valid && m_lup_ready) begin
        req_q.push_back('{m_lup_key, m_lup_last});
        lup_count++;
      end
      if (s_rsp_valid && s_rsp_ready) rsp_taken = 1'b1;
      if (m_upd_valid) begin
        pend_q.push_back('{m_upd_key, cyc + upd_dly});
        upd_count++;
      end
      if (tbl_clear) begin
        chk("clear_vs_upd", {63'd0, m_upd_valid}, 64'd0);
        tbl.delete();
        pend_q.delete();
        clr_count++;
        clr_cyc = cyc;
      end
      if (m_out_valid && m_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got key %0h keep %0b last %0b, expected no beat", m_out_key, m_out_keep, m_out_last);
        end else begin
          e = exp_q.pop_front();
          chk("out_keep", {63'd0, m_out_keep}, {63'd0, e.keep});
          chk("out_last", {63'd0, m_out_last}, {63'd0, e.last});
          if (e.keep) chk("out_key", {32'd0, m_out_key}, {32'd0, e.key});
          if (e.last) beat_cyc = cyc;
        end
      end
    end
  end

  // Table responder and downstream/lookup ready drivers.
  initial forever begin
    @(posedge aclk);
    #1;
    if (!aresetn) begin
      s_rsp_valid = 1'b0;
      rsp_taken   = 1'b0;
      req_q.delete();
    end else begin
      if (rsp_taken) begin
        rsp_taken   = 1'b0;
        s_rsp_valid = 1'b0;
        if (req_q.size() > 0) req_q.delete(0);
      end
      if (!s_rsp_valid && !rsp_hold && req_q.size() > 0 && $urandom_range(0, 99) >= rsp_gap) begin
        s_rsp_valid = 1'b1;
        s_rsp_last  = req_q[0].last;
        s_rsp_hit   = tbl.exists(req_q[0].key);
        s_rsp_key   = $urandom;
      end
    end
    m_out_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    m_lup_ready = (lup_mode == 2) ? ($urandom_range(0, 3) != 0) : (lup_mode == 1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic start_stream();
    seen.delete();
    s_len    = 0;
    s_uniq   = 0;
    upd_base = upd_count;
    clr_base = clr_count;
  endtask

  // Reference: a key is emitted iff it is the first of its value in the stream.
  task automatic model_push(input logic [KB-1:0] k, input logic last);
    s_len++;
    if (!seen.exists(k)) begin
      seen[k] = 1'b1;
      s_uniq++;
      exp_q.push_back('{k, 1'b1, last});
    end else if (last) begin
      exp_q.push_back('{k, 1'b0, 1'b1});
    end
  endtask

  task automatic send_key(input logic [KB-1:0] k, input logic last);
    int n;
    bit done;
    n = 0;
    done = 0;
    s_key_valid = 1'b1;
    s_key_data  = k;
    s_key_last  = last;
    while (!done && n < 500) begin
      @(negedge aclk);
      if (s_key_ready) done = 1;
      n++;
      @(posedge aclk);
      #1;
    end
    s_key_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL key_accept_timeout: key %0h not accepted within 500 cycles", k);
    end else begin
      model_push(k, last);
    end
  endtask

  task automatic finish_stream(input string tag);
    int n;
    n = 0;
    while (clr_count == clr_base && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    @(posedge aclk);
    #1;
    if (clr_count == clr_base) begin
      checks++;
      errors++;
      $display("FAIL %s_clear_timeout: no tbl_clear within 3000 cycles", tag);
    end else begin
      chk({tag, "_stat_in"}, 64'(stat_in), 64'(s_len));
      chk({tag, "_stat_out"}, 64'(stat_out), 64'(s_uniq));
      chk({tag, "_upd_count"}, 64'(upd_count - upd_base), 64'(s_uniq));
      chk({tag, "_clear_gap"}, 64'(clr_cyc - beat_cyc), 64'd1);
      chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      @(negedge aclk);
      chk({tag, "_clear_pulses"}, 64'(clr_count - clr_base), 64'd1);
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_list(input string tag, input int keys[$]);
    start_stream();
    foreach (keys[i]) send_key(KB'(keys[i]), i == keys.size() - 1);
    finish_stream(tag);
  endtask

  initial begin
    int len, stall_bad, lbase, ubase;
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, stall_bad, lbase, ubase;
    idle(3);
    @(negedge aclk);
    chk("rst_out_valid", {63'd0, m_out_valid}, 64'd0);
    chk("rst_tbl_clear", {63'd0, tbl_clear}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stat_in", 64'(stat_in), 64'd0);
    chk("rst_stat_out", 64'(stat_out), 64'd0);
    chk("rst_upd_valid", {63'd0, m_upd_valid}, 64'd0);
    chk("rst_key_ready", {63'd0, s_key_ready}, 64'd1);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    idle(2);

    send_list("basic", '{5, 7, 5, 9, 7, 11});
    upd_dly = 4;
    send_list("b2b", '{3, 3, 8});
    send_list("duplast", '{4, 4});
    upd_dly = 2;

    // Outstanding limit, then downstream backpressure with responses pending.
    start_stream();
    rsp_hold = 1;
    lbase = lup_count;
    ubase = upd_count;
    for (int i = 0; i < 4; i++) send_key(KB'(20 + i), 1'b0);
    stall_bad = 0;
    s_key_valid = 1'b1;
    s_key_data  = 24;
    s_key_last  = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      if (s_key_ready) stall_bad++;
      @(posedge aclk);
      #1;
    end
    s_key_valid = 1'b0;
    chk("outst_stall", 64'(stall_bad), 64'd0);
    chk("outst_lookups", 64'(lup_count - lbase), 64'd4);
    rdy_mode = 0;
    rsp_hold = 0;
    idle(10);
    @(negedge aclk);
    chk("bp_rsp_ready", {63'd0, s_rsp_ready}, 64'd0);
    chk("bp_out_valid", {63'd0, m_out_valid}, 64'd1);
    chk("bp_upd_count", 64'(upd_count - ubase), 64'd1);
    chk("bp_key_ready", {63'd0, s_key_ready}, 64'd1);
    @(posedge aclk);
    #1;
    rdy_mode = 1;
    send_key(24, 1'b1);
    finish_stream("bp");

    // Reset while draining with two lookups outstanding.
    start_stream();
    rsp_hold = 1;
    send_key(10, 1'b0);
    send_key(5, 1'b1);
    idle(2);
    @(negedge aclk);
    chk("drain_busy", {63'd0, busy}, 64'd1);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    idle(3);
    @(negedge aclk);
    chk("mrst_out_valid", {63'd0, m_out_valid}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_stat_in", 64'(stat_in), 64'd0);
    chk("mrst_stat_out", 64'(stat_out), 64'd0);
    chk("mrst_tbl_clear", {63'd0, tbl_clear}, 64'd0);
    @(posedge aclk);
    #1;
    exp_q.delete();
    aresetn  = 1'b1;
    rsp_hold = 0;
    idle(1);
    send_list("post_rst", '{5});

    // Randomized streams with random backpressure, response gaps and update visibility delay.
    lup_mode = 2;
    rdy_mode = 2;
    for (int s = 0; s < 40; s++) begin
      upd_dly = $urandom_range(0, 4);
      rsp_gap = $urandom_range(0, 60);
      len = $urandom_range(1, 12);
      start_stream();
      for (int i = 0; i < len; i++) begin
        send_key(KB'(100 + $urandom_range(0, 9)), i == len - 1);
        idle($urandom_range(0, 2));
      end
      finish_stream("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
